spike_flit_serializer: RTL and testbench

//  Neuron-side egress stage feeding the router local input port.

---
 rtl/spike_flit_serializer_pkg.sv | 19 +
 rtl/spike_pkt_fifo.sv | 56 +++++
 rtl/spike_flit_serializer.sv | 158 +++++++++++++++
 tb/tb_spike_flit_serializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spike_flit_serializer_pkg.sv
// Shared constants and types for the spike flit serializer: default sizes,
// packet field positions and the serializer FSM state type.
package spike_flit_serializer_pkg;

  localparam int DEF_PACKET_SIZE   = 32;
  localparam int DEF_FLIT_SIZE     = 4;
  localparam int DEF_FLITS_PER_PKT = DEF_PACKET_SIZE / DEF_FLIT_SIZE;

  localparam int X_FIELD_MSB = 31;
  localparam int X_FIELD_LSB = 24;
  localparam int Y_FIELD_MSB = 23;
  localparam int Y_FIELD_LSB = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/spike_pkt_fifo.sv
// Synchronous packet FIFO with a registered occupancy count. A push that
// arrives while full is still accepted when a pop happens at the same edge.
module spike_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // The popped slot is read before the edge, so it can be rewritten at that edge.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spike_flit_serializer.sv
// Neuron egress stage: buffers spike packets and serializes them MSB-first into
// router flits. Optional LOCAL_BYPASS_EN diverts self-addressed packets to bypass ports.
module spike_flit_serializer
  import spike_flit_serializer_pkg::*;
#(
  parameter int         PACKET_SIZE  = DEF_PACKET_SIZE,
  parameter int         FLIT_SIZE    = DEF_FLIT_SIZE,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] X_COORDINATE = 8'd0,
  parameter logic [7:0] Y_COORDINATE = 8'd0,
  parameter int         DROP_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PACKET_SIZE-1:0] packet_in,
  input  logic                   packet_valid,
  input  logic                   router_full,
  output logic [FLIT_SIZE-1:0]   flit_out,
  output logic                   flit_wr_en,
  output logic                   busy,
  output logic                   fifo_full,
  output logic [DROP_CNT_W-1:0]  drop_cnt
`ifdef LOCAL_BYPASS_EN
  ,
  output logic [PACKET_SIZE-1:0] bypass_packet,
  output logic                   bypass_valid
`endif
);

  localparam int NUM_FLITS = PACKET_SIZE / FLIT_SIZE;
  localparam int IDX_W     = $clog2(NUM_FLITS) + 1;
  localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(NUM_FLITS);
`ifdef LOCAL_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  ser_state_e             state_q, state_d;
  logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FLIT_SIZE-1:0]   flit_q, flit_d;
  logic                   wr_en_q, wr_en_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   is_local;
  logic                   fifo_push, fifo_pop, fifo_empty;
  logic [PACKET_SIZE-1:0] fifo_head;
  logic                   drop;

  assign is_local = BYPASS_EN && packet_valid
                 && (packet_in[X_FIELD_MSB:X_FIELD_LSB] == X_COORDINATE)
                 && (packet_in[Y_FIELD_MSB:Y_FIELD_LSB] == Y_COORDINATE);
  assign fifo_push = packet_valid && !is_local;
  assign drop      = fifo_push && fifo_full && !fifo_pop;

  spike_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PACKET_SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (packet_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    flit_d   = flit_q;
    wr_en_d  = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        // One idle edge after the last flit; the next packet is loaded there.
        if (idx_q == IDX_DONE) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            idx_d    = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!router_full) begin
          flit_d  = shreg_q[PACKET_SIZE-1 -: FLIT_SIZE];
          wr_en_d = 1'b1;
          shreg_d = shreg_q << FLIT_SIZE;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      flit_q     <= '0;
      wr_en_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      flit_q     <= flit_d;
      wr_en_q    <= wr_en_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign flit_out   = flit_q;
  assign flit_wr_en = wr_en_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = !fifo_empty || (state_q == ST_SEND);

`ifdef LOCAL_BYPASS_EN
  logic [PACKET_SIZE-1:0] byp_pkt_q, byp_pkt_d;
  logic                   byp_vld_q, byp_vld_d;

  always_comb begin
    byp_vld_d = is_local;
    byp_pkt_d = is_local ? packet_in : byp_pkt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_pkt_q <= '0;
      byp_vld_q <= 1'b0;
    end else begin
      byp_pkt_q <= byp_pkt_d;
      byp_vld_q <= byp_vld_d;
    end
  end

  assign bypass_packet = byp_pkt_q;
  assign bypass_valid  = byp_vld_q;
`endif

endmodule

// File: tb/tb_spike_flit_serializer.sv
// Scoreboard bench for spike_flit_serializer; build with +define+LOCAL_BYPASS_EN
// to also exercise the bypass path.
module tb_spike_flit_serializer;

  logic        clk;
  logic        rst_n;
  logic [31:0] packet_in;
  logic        packet_valid;
  logic        router_full;
  logic [3:0]  flit_out;
  logic        flit_wr_en;
  logic        busy;
  logic        fifo_full;
  logic [7:0]  drop_cnt;
`ifdef LOCAL_BYPASS_EN
  logic [31:0] bypass_packet;
  logic        bypass_valid;
`endif

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int w0       = 0;
  logic [3:0] exp_q [$];

  spike_flit_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .packet_in    (packet_in),
    .packet_valid (packet_valid),
    .router_full  (router_full),
    .flit_out     (flit_out),
    .flit_wr_en   (flit_wr_en),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .drop_cnt     (drop_cnt)
`ifdef LOCAL_BYPASS_EN
    ,
    .bypass_packet(bypass_packet),
    .bypass_valid (bypass_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every written flit must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && flit_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_flit actual=%0h required=none", flit_out);
      end else begin
        check("flit", {28'd0, flit_out}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a posedge; the packet is captured at the next posedge.
  task automatic pulse(input logic [31:0] p, input bit expect_flits);
    packet_in    = p;
    packet_valid = 1'b1;
    if (expect_flits)
      for (int i = 0; i < 8; i++) exp_q.push_back(p[31-4*i -: 4]);
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    packet_in    = '0;
    packet_valid = 1'b0;
    router_full  = 1'b0;
    #12;
    check("rst_flit_out", {28'd0, flit_out}, 32'd0);
    check("rst_wr_en",    {31'd0, flit_wr_en}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_fifo_full",{31'd0, fifo_full}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single packet, first flit after edge N+2
    w0 = wr_cnt;
    pulse(32'h0102ABCD, 1'b1);
    check("t1_wr_en_n",   {31'd0, flit_wr_en}, 32'd0);
    @(posedge clk); #1;
    check("t1_wr_en_n1",  {31'd0, flit_wr_en}, 32'd0);
    check("t1_busy_n1",   {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_wr_en_n2",  {31'd0, flit_wr_en}, 32'd1);
    check("t1_flit0_n2",  {28'd0, flit_out}, 32'd0);
    wait_idle();
    check("t1_flit_count", wr_cnt - w0, 32'd8);

    // 2: backpressure for 3 cycles after flit index 2
    w0 = wr_cnt;
    pulse(32'h89ABCDEF, 1'b1);
    repeat (4) @(posedge clk);
    #1 router_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t2_stall_wr_en", {31'd0, flit_wr_en}, 32'd0);
      check("t2_stall_hold",  {28'd0, flit_out}, 32'hA);
    end
    router_full = 1'b0;
    wait_idle();
    check("t2_flit_count", wr_cnt - w0, 32'd8);

    // 3: router blocked, 6 packets -> 1 in shreg, 4 buffered, 1 dropped
    w0 = wr_cnt;
    router_full = 1'b1;
    pulse(32'h11111111, 1'b1);
    pulse(32'h22223333, 1'b1);
    pulse(32'h44445555, 1'b1);
    pulse(32'h66667777, 1'b1);
    pulse(32'h88889999, 1'b1);
    pulse(32'hEEEEEEEE, 1'b0);
    check("t3_drop_cnt",  {24'd0, drop_cnt}, 32'd1);
    check("t3_fifo_full", {31'd0, fifo_full}, 32'd1);
    check("t3_wr_en",     {31'd0, flit_wr_en}, 32'd0);
    // push into a full FIFO on the very edge that pops it: no drop
    router_full = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    pulse(32'h5A5AC3C3, 1'b1);
    check("t3_pop_push_drop", {24'd0, drop_cnt}, 32'd1);
    check("t3_pop_push_full", {31'd0, fifo_full}, 32'd1);
    wait_idle();
    check("t3_flit_count", wr_cnt - w0, 32'd48);

    // 4: back-to-back packets: 8 flits, 1 gap, 8 flits
    w0 = wr_cnt;
    pulse(32'h2468ACE0, 1'b1);
    pulse(32'h13579BDF, 1'b1);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      check("t4_wr_pattern", {31'd0, flit_wr_en}, (i == 8) ? 32'd0 : 32'd1);
      if (i == 16) check("t4_busy_last", {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    check("t4_busy_fall", {31'd0, busy}, 32'd0);
    check("t4_flit_count", wr_cnt - w0, 32'd16);
    @(posedge clk); #1;

    // 5: asynchronous reset mid-packet
    pulse(32'hFEDCBA98, 1'b1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_wr_en",     {31'd0, flit_wr_en}, 32'd0);
    check("t5_flit_out",  {28'd0, flit_out}, 32'd0);
    check("t5_busy",      {31'd0, busy}, 32'd0);
    check("t5_drop_cnt",  {24'd0, drop_cnt}, 32'd0);
    check("t5_fifo_full", {31'd0, fifo_full}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    w0 = wr_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t5_residual_flits", wr_cnt - w0, 32'd0);
    check("t5_busy_after",     {31'd0, busy}, 32'd0);

`ifdef LOCAL_BYPASS_EN
    // 6: self-addressed packet leaves through the bypass port only
    w0 = wr_cnt;
    pulse(32'h0000BEEF, 1'b0);
    check("t6_bypass_valid", {31'd0, bypass_valid}, 32'd1);
    check("t6_bypass_data",  bypass_packet, 32'h0000BEEF);
    check("t6_busy",         {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("t6_bypass_pulse", {31'd0, bypass_valid}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_flits", wr_cnt - w0, 32'd0);
    check("t6_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`else
    // without bypass, a self-addressed packet is serialized like any other
    w0 = wr_cnt;
    pulse(32'h0000BEEF, 1'b1);
    wait_idle();
    check("t6_flit_count", wr_cnt - w0, 32'd8);
`endif

    check("exp_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
